// File: rtl/dds_sweep_controller_pkg.sv
// Shared types and helpers for the DDS frequency-sweep controller.
// Optional triangle sweep is enabled by defining DDS_SWEEP_TRIANGLE_EN.
package dds_pkg;

    localparam int unsigned TW_WIDTH_DEF    = 8;
    localparam int unsigned DWELL_WIDTH_DEF = 8;
    // Helpers work at this width; TW_WIDTH must not exceed it.
    localparam int unsigned TW_MAX          = 32;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } dds_state_e;

    // a + b, saturating at limit; the extra bit catches the carry out.
    function automatic logic [TW_MAX-1:0] clamp_add(
        input logic [TW_MAX-1:0] a,
        input logic [TW_MAX-1:0] b,
        input logic [TW_MAX-1:0] limit
    );
        logic [TW_MAX:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, limit}) begin
            return limit;
        end else begin
            return sum[TW_MAX-1:0];
        end
    endfunction

    // a - b, saturating at floor without ever wrapping below zero.
    function automatic logic [TW_MAX-1:0] clamp_sub(
        input logic [TW_MAX-1:0] a,
        input logic [TW_MAX-1:0] b,
        input logic [TW_MAX-1:0] floor
    );
        if (b > a) begin
            return floor;
        end else if ((a - b) < floor) begin
            return floor;
        end else begin
            return a - b;
        end
    endfunction

endpackage

// File: rtl/dds_sweep_controller_if.sv
// Control-side bus of the sweep controller: configuration, start/stop and
// busy/done/error handshake. master = register/control logic, slave = controller.
interface dds_sweep_controller_if
    import dds_pkg::*;
#(
    parameter int unsigned TW_WIDTH    = TW_WIDTH_DEF,
    parameter int unsigned DWELL_WIDTH = DWELL_WIDTH_DEF
);

    logic                   Start_i;
    logic                   Stop_i;
    logic [TW_WIDTH-1:0]    StartWord_i;
    logic [TW_WIDTH-1:0]    StopWord_i;
    logic [TW_WIDTH-1:0]    Step_i;
    logic [DWELL_WIDTH-1:0] Dwell_i;
    logic                   Continuous_i;
    logic                   Triangle_i;
    logic                   Busy_o;
    logic                   Done_o;
    logic                   StepStrobe_o;
    logic                   Error_o;

    modport master (
        output Start_i, Stop_i, StartWord_i, StopWord_i, Step_i, Dwell_i,
               Continuous_i, Triangle_i,
        input  Busy_o, Done_o, StepStrobe_o, Error_o
    );

    modport slave (
        input  Start_i, Stop_i, StartWord_i, StopWord_i, Step_i, Dwell_i,
               Continuous_i, Triangle_i,
        output Busy_o, Done_o, StepStrobe_o, Error_o
    );

endinterface

// File: rtl/dds_sweep_controller_dwell_counter.sv
// Counts DDS period-wrap pulses and flags the one that completes the dwell.
// A dwell of 0 behaves as 1. Expire is combinational so the word register in
// the parent can update on the same edge as the qualifying Overflow_i.
module dds_dwell_counter
    import dds_pkg::*;
#(
    parameter int unsigned DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Clear,
    input  logic                   Overflow_i,
    input  logic [DWELL_WIDTH-1:0] Dwell,
    output logic                   Expire
);

    logic [DWELL_WIDTH-1:0] r_count;
    logic [DWELL_WIDTH-1:0] w_target;

    assign w_target = (Dwell == '0) ? DWELL_WIDTH'(1) : Dwell;
    assign Expire   = Overflow_i && !Clear && (r_count == (w_target - DWELL_WIDTH'(1)));

    // Period counter: cleared on request, restarts after each expiry.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (Clear || Expire) begin
            r_count <= '0;
        end else if (Overflow_i) begin
            r_count <= r_count + DWELL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/dds_sweep_controller.sv
// Linear frequency-sweep sequencer driving the DDS tuning word.
// Define DDS_SWEEP_TRIANGLE_EN to build the DOWN leg (triangle sweeps);
// otherwise Triangle_i is ignored and only single/continuous up-sweeps exist.
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int unsigned TW_WIDTH    = TW_WIDTH_DEF,
    parameter int unsigned DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    dds_sweep_controller_if.slave ctrl,
    input  logic                  Overflow_i,
    output logic [TW_WIDTH-1:0]   TuningWord_o
);

    dds_state_e             r_state;
    logic [TW_WIDTH-1:0]    r_word;
    logic [TW_WIDTH-1:0]    r_start;
    logic [TW_WIDTH-1:0]    r_stop;
    logic [TW_WIDTH-1:0]    r_step;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_cont;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_strobe;
    logic                   r_error;

    logic                   w_expire;
    logic                   w_clear;
    logic [TW_WIDTH-1:0]    w_up_next;

    assign TuningWord_o      = r_word;
    assign ctrl.Busy_o       = r_busy;
    assign ctrl.Done_o       = r_done;
    assign ctrl.StepStrobe_o = r_strobe;
    assign ctrl.Error_o      = r_error;

    assign w_clear   = !r_busy || ctrl.Stop_i;
    assign w_up_next = TW_WIDTH'(clamp_add(TW_MAX'(r_word), TW_MAX'(r_step), TW_MAX'(r_stop)));

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic                r_tri;
    logic [TW_WIDTH-1:0] w_down_next;
    logic [TW_WIDTH-1:0] w_turn_word;
    logic [TW_WIDTH-1:0] w_rise_word;

    assign w_down_next = TW_WIDTH'(clamp_sub(TW_MAX'(r_word), TW_MAX'(r_step), TW_MAX'(r_start)));
    assign w_turn_word = TW_WIDTH'(clamp_sub(TW_MAX'(r_stop), TW_MAX'(r_step), TW_MAX'(r_start)));
    assign w_rise_word = TW_WIDTH'(clamp_add(TW_MAX'(r_start), TW_MAX'(r_step), TW_MAX'(r_stop)));
`else
    logic w_unused_tri;
    assign w_unused_tri = ctrl.Triangle_i;
`endif

    dds_dwell_counter #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell (
        .Clock      (Clock),
        .Reset      (Reset),
        .Clear      (w_clear),
        .Overflow_i (Overflow_i),
        .Dwell      (r_dwell),
        .Expire     (w_expire)
    );

    // Sweep FSM with word register and registered handshake pulses.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_word   <= '0;
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_cont   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_error  <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            r_tri    <= 1'b0;
`endif
        end else begin
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
            r_error  <= 1'b0;
            if (ctrl.Stop_i) begin
                r_state <= IDLE;
                r_word  <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (ctrl.Start_i) begin
                            if (ctrl.Step_i == '0 || ctrl.StartWord_i > ctrl.StopWord_i) begin
                                r_error <= 1'b1;
                            end else begin
                                r_start <= ctrl.StartWord_i;
                                r_stop  <= ctrl.StopWord_i;
                                r_step  <= ctrl.Step_i;
                                r_dwell <= ctrl.Dwell_i;
                                r_cont  <= ctrl.Continuous_i;
`ifdef DDS_SWEEP_TRIANGLE_EN
                                r_tri   <= ctrl.Triangle_i;
`endif
                                r_word  <= ctrl.StartWord_i;
                                r_busy  <= 1'b1;
                                r_state <= UP;
                            end
                        end
                    end
                    UP: begin
                        if (w_expire) begin
                            if (r_word == r_stop) begin
                                // Strobe only flags a real change: with Start==Stop the
                                // reload/turn keeps the same word.
`ifdef DDS_SWEEP_TRIANGLE_EN
                                if (r_tri) begin
                                    r_state  <= DOWN;
                                    r_word   <= w_turn_word;
                                    r_strobe <= (w_turn_word != r_word);
                                end else
`endif
                                if (r_cont) begin
                                    r_word   <= r_start;
                                    r_strobe <= (r_start != r_word);
                                end else begin
                                    r_state <= IDLE;
                                    r_word  <= '0;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_word   <= w_up_next;
                                r_strobe <= 1'b1;
                            end
                        end
                    end
`ifdef DDS_SWEEP_TRIANGLE_EN
                    DOWN: begin
                        if (w_expire) begin
                            if (r_word == r_start) begin
                                if (r_cont) begin
                                    r_state  <= UP;
                                    r_word   <= w_rise_word;
                                    r_strobe <= (w_rise_word != r_word);
                                end else begin
                                    r_state <= IDLE;
                                    r_word  <= '0;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_word   <= w_down_next;
                                r_strobe <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        r_state <= IDLE;
                        r_word  <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Self-checking bench for dds_sweep_controller: directed cases plus random
// single sweeps, checked against a word-list model of the sweep.
module tb_dds_sweep_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Overflow = 1'b0;
    logic [7:0] tw;

    int checks = 0;
    int errors = 0;

    int unsigned seq[$];

    always #5 Clock = ~Clock;

    dds_sweep_controller_if #(.TW_WIDTH(8), .DWELL_WIDTH(8)) bus ();

    dds_sweep_controller #(
        .TW_WIDTH    (8),
        .DWELL_WIDTH (8)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ctrl         (bus.slave),
        .Overflow_i   (Overflow),
        .TuningWord_o (tw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Word list of one sweep: up leg from s to e, then (triangle) back down to s.
    function automatic void build_seq(input int unsigned s, input int unsigned e,
                                      input int unsigned st, input bit tri_en);
        int unsigned v;
        seq.delete();
        v = s;
        while (1) begin
            seq.push_back(v);
            if (v == e) break;
            v = (v + st > e) ? e : v + st;
        end
        if (tri_en) begin
            v = e;
            while (1) begin
                v = (v < s + st) ? s : v - st;
                seq.push_back(v);
                if (v == s) break;
            end
        end
    endfunction

    task automatic start_sweep(input int unsigned s, input int unsigned e, input int unsigned st,
                               input int unsigned d, input bit cont, input bit tri_en);
        bus.StartWord_i  = 8'(s);
        bus.StopWord_i   = 8'(e);
        bus.Step_i       = 8'(st);
        bus.Dwell_i      = 8'(d);
        bus.Continuous_i = cont;
        bus.Triangle_i   = tri_en;
        bus.Start_i      = 1'b1;
        tick();
        bus.Start_i      = 1'b0;
    endtask

    task automatic run_sweep(input int unsigned s, input int unsigned e, input int unsigned st,
                             input int unsigned d, input bit cont, input bit tri_en,
                             input int unsigned nwords);
        int unsigned deff;
        int unsigned total;
        int unsigned cur;
        int unsigned nxt;
        int unsigned g;
        build_seq(s, e, st, tri_en);
        deff  = (d == 0) ? 1 : d;
        total = cont ? nwords : seq.size();
        // Overflow while idle must not move anything.
        Overflow = 1'b1;
        tick();
        Overflow = 1'b0;
        check("idle_ovf_tw", tw, 0);
        check("idle_ovf_busy", bus.Busy_o, 0);
        start_sweep(s, e, st, d, cont, tri_en);
        check("start_tw", tw, seq[0]);
        check("start_busy", bus.Busy_o, 1);
        check("start_strobe", bus.StepStrobe_o, 0);
        for (int unsigned k = 0; k < total; k++) begin
            cur = seq[k % seq.size()];
            for (int unsigned p = 1; p <= deff; p++) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    // Sometimes throw a fresh Start_i with junk config: must be ignored.
                    if ($urandom_range(0, 1) == 1) begin
                        bus.Start_i     = 1'b1;
                        bus.StartWord_i = 8'($urandom_range(0, 255));
                        bus.StopWord_i  = 8'($urandom_range(0, 255));
                        bus.Step_i      = 8'($urandom_range(0, 255));
                        bus.Dwell_i     = 8'($urandom_range(0, 255));
                    end
                    tick();
                    bus.Start_i = 1'b0;
                    check("hold_tw", tw, cur);
                    check("hold_strobe", bus.StepStrobe_o, 0);
                    check("hold_busy", bus.Busy_o, 1);
                    check("hold_error", bus.Error_o, 0);
                end
                Overflow = 1'b1;
                tick();
                Overflow = 1'b0;
                if (p < deff) begin
                    check("dwell_tw", tw, cur);
                    check("dwell_strobe", bus.StepStrobe_o, 0);
                end else if (!cont && k == total - 1) begin
                    check("done_pulse", bus.Done_o, 1);
                    check("done_busy", bus.Busy_o, 0);
                    check("done_tw", tw, 0);
                    tick();
                    check("done_clear", bus.Done_o, 0);
                    check("done_busy_after", bus.Busy_o, 0);
                end else begin
                    nxt = seq[(k + 1) % seq.size()];
                    check("step_tw", tw, nxt);
                    check("step_strobe", bus.StepStrobe_o, (nxt != cur) ? 1 : 0);
                    check("step_done", bus.Done_o, 0);
                end
            end
        end
        if (cont) begin
            bus.Stop_i = 1'b1;
            tick();
            bus.Stop_i = 1'b0;
            check("stop_busy", bus.Busy_o, 0);
            check("stop_tw", tw, 0);
            check("stop_done", bus.Done_o, 0);
            check("stop_strobe", bus.StepStrobe_o, 0);
        end
    endtask

    task automatic err_case(input int unsigned s, input int unsigned e, input int unsigned st);
        start_sweep(s, e, st, 1, 0, 0);
        check("err_pulse", bus.Error_o, 1);
        check("err_busy", bus.Busy_o, 0);
        check("err_tw", tw, 0);
        tick();
        check("err_clear", bus.Error_o, 0);
        check("err_busy_after", bus.Busy_o, 0);
    endtask

    initial begin
        int unsigned s;
        int unsigned e;
        int unsigned st;
        int unsigned d;
        bit          tri_en;
        bus.Start_i      = 1'b0;
        bus.Stop_i       = 1'b0;
        bus.StartWord_i  = '0;
        bus.StopWord_i   = '0;
        bus.Step_i       = '0;
        bus.Dwell_i      = '0;
        bus.Continuous_i = 1'b0;
        bus.Triangle_i   = 1'b0;

        repeat (3) tick();
        check("rst_tw", tw, 0);
        check("rst_busy", bus.Busy_o, 0);
        check("rst_done", bus.Done_o, 0);
        check("rst_strobe", bus.StepStrobe_o, 0);
        check("rst_error", bus.Error_o, 0);
        Reset = 1'b1;
        tick();

        run_sweep(10, 40, 10, 2, 0, 0, 0);
        run_sweep(200, 250, 30, 1, 0, 0, 0);
        run_sweep(240, 255, 20, 1, 0, 0, 0);
        run_sweep(5, 15, 5, 1, 1, 0, 7);

        err_case(10, 40, 0);
        err_case(50, 20, 10);

        // Start and Stop together in idle: Stop wins, no error.
        bus.StartWord_i = 8'd10;
        bus.StopWord_i  = 8'd40;
        bus.Step_i      = 8'd10;
        bus.Start_i     = 1'b1;
        bus.Stop_i      = 1'b1;
        tick();
        bus.Start_i = 1'b0;
        bus.Stop_i  = 1'b0;
        check("startstop_error", bus.Error_o, 0);
        check("startstop_busy", bus.Busy_o, 0);
        check("startstop_tw", tw, 0);

        run_sweep(77, 77, 5, 3, 0, 0, 0);

`ifdef DDS_SWEEP_TRIANGLE_EN
        run_sweep(0, 30, 10, 1, 0, 1, 0);
`endif

        // Asynchronous reset in the middle of a sweep.
        start_sweep(10, 40, 10, 1, 0, 0);
        Overflow = 1'b1;
        tick();
        Overflow = 1'b0;
        check("pre_reset_tw", tw, 20);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_tw", tw, 0);
        check("async_rst_busy", bus.Busy_o, 0);
        check("async_rst_strobe", bus.StepStrobe_o, 0);
        check("async_rst_done", bus.Done_o, 0);
        tick();
        Reset = 1'b1;
        tick();
        run_sweep(10, 40, 10, 1, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            s  = $urandom_range(0, 200);
            e  = s + $urandom_range(0, 55);
            st = $urandom_range(1, 70);
            d  = $urandom_range(0, 3);
`ifdef DDS_SWEEP_TRIANGLE_EN
            tri_en = 1'($urandom_range(0, 1));
`else
            tri_en = 1'b0;
`endif
            run_sweep(s, e, st, d, 0, tri_en, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
